param_register_file: RTL and testbench
======================================

Name: param_register_file

Overview:
- Parametrised next-generation register file for the core datapath, with configurable data width and general-purpose register (GPR) count.
- Holds AR, DR, PC, IR, AC, R1..R<NUM_GPR> and constant core-ID registers IDX/IDY.
- Exposes one encoded bus read port, one encoded write port, per-GPR clear/increment, PC increment and a registered ALU operand latch.
- Sits between the control unit and the ALU/memory interfaces; drives BOUT onto the shared datapath bus.

Parameters:
- DATA_W, 16: width of every register and bus.
- NUM_GPR, 7: number of general registers R1..R<NUM_GPR>; legal range 1..27.
- CORE_X, 0: reset/constant value of IDX (DATA_W bits).
- CORE_Y, 0: reset/constant value of IDY (DATA_W bits).
- INC_MASK, 7'b0000010: bit i set means GPR R<i+1> supports increment. Default enables R2 only. Width NUM_GPR.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- WEN  in  1  write enable for register WSEL
- WSEL  in  SEL_W  write target index
- REN  in  1  read enable for register RSEL onto REGOUT
- RSEL  in  SEL_W  read source index
- MEMREAD  in  1  BOUT and write-data source select: DIN when 1
- DIN  in  DATA_W  data-memory read data
- BIN  in  DATA_W  datapath bus write data
- INSIN  in  DATA_W  instruction-memory data; written to IR when WSEL=IR
- CLR  in  NUM_GPR  synchronous per-GPR clear
- INC  in  NUM_GPR  per-GPR increment, masked by INC_MASK
- PCINC  in  1  PC increment
- ALU_LD  in  1  latch operand selected by ALU_SEL into ALUOUT
- ALU_SEL  in  SEL_W  ALU operand index; IDX/IDY codes allowed
- BOUT  out  DATA_W  MEMREAD ? DIN : REGOUT
- ALUOUT  out  DATA_W  registered ALU operand
- DMADDR, IMADDR, DOUT, ACOUT, IROUT  out  DATA_W  live AR, PC, DR, AC and IR values
- RD_ERR  out  1  sticky illegal-index flag

Behaviour:
- Clock/reset: single clock domain. Asynchronous reset, active-low (rst_n).
- Index map: 0=AR, 1=DR, 2=PC, 3=IR, 4=AC, 5..4+NUM_GPR=R1..R<NUM_GPR>, 5+NUM_GPR=IDX, 6+NUM_GPR=IDY.
- Index width: SEL_W = clog2(7+NUM_GPR), defined in the package.
- Reset values:
  - all registers, ALUOUT and RD_ERR = 0
  - IDX = CORE_X, IDY = CORE_Y; these are read-only and writes to them are ignored.
- Write path (1-cycle latency): write data is DIN if MEMREAD, else BIN. Exception: IR always takes INSIN. The new value is visible on outputs the cycle after the edge.
- Read path (combinational):
  - REGOUT = register[RSEL] when REN, else 0.
  - BOUT = MEMREAD ? DIN : REGOUT.
  - A read of a register written in the same cycle returns the old value.
- Increment:
  - INC[i] adds 1 to R<i+1> modulo 2^DATA_W, only if INC_MASK[i]=1; otherwise ignored.
  - PCINC adds 1 to PC, wrapping from all-ones to 0.
- Same-register priority within one cycle: CLR > WEN > INC/PCINC. Different registers update independently in the same cycle.
- ALU latch: on ALU_LD, ALUOUT <= register[ALU_SEL] (pre-edge value); otherwise ALUOUT holds. 1-cycle latency.
- RD_ERR: set on any edge where REN, WEN or ALU_LD uses an index above 6+NUM_GPR. Cleared only by reset.
  - Illegal reads return 0.
  - Illegal writes have no effect.
  - An illegal ALU_SEL loads 0.
- Reset asserted mid-cycle immediately forces reset values. Pending INC, PCINC or WEN in that cycle are lost.

Optional Feature:
- Macro: RF_INC_SATURATE_EN.
- Defined: GPR increment and PCINC saturate at all-ones (2^DATA_W-1) instead of wrapping. A saturating event sets a sticky INC_SAT output (1 bit, reset 0).
- Undefined: modulo wrap as specified above; INC_SAT port absent.

Decomposition:
- Package rf_pkg holds:
  - index constants IDX_AR..IDX_AC and GPR_BASE=5
  - function sel_w(NUM_GPR)
  - typedef rf_idx_t
- Natural sub-module: rf_gpr_cell, one GPR with clear/write/increment priority and an INC_EN parameter, instantiated NUM_GPR times by generate.

Test Plan:
- Reset: rst_n=0 with CORE_X=16'h0003, CORE_Y=16'h0005 -> all outputs 0. REN, RSEL=IDX reads 16'h0003; RSEL=IDY reads 16'h0005.
- Write/read: WEN, WSEL=5 (R1), BIN=16'hA5A5 -> next cycle REN, RSEL=5 gives BOUT=16'hA5A5. Same-cycle read returns the old value, 0.
- Memory write: MEMREAD=1, DIN=16'h1234, WEN, WSEL=1 -> DOUT=16'h1234 next cycle. BOUT=16'h1234 combinationally while MEMREAD is high.
- Wrap/priority:
  - R2=16'hFFFF, INC[1] -> R2=0.
  - Simultaneous CLR[1], WEN (WSEL=6) and INC[1] -> R2=0.
  - WEN and INC[1] together with BIN=7 -> R2=7.
  - INC[0] on R1 with mask 0 -> R1 unchanged.
- ALU/PC: PC=16'hFFFE, PCINC for 2 cycles -> IMADDR=16'hFFFF, then 0. ALU_LD, ALU_SEL=IDX -> ALUOUT=16'h0003 next cycle.
- Error: WEN, WSEL=31 with NUM_GPR=7 -> no register changes, RD_ERR=1 and sticky until rst_n pulses low.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared index map and sizing helpers for the parametrised register file.
// Optional feature macro: RF_INC_SATURATE_EN (saturating increments).
package rf_pkg;

  localparam int unsigned IDX_AR   = 0;
  localparam int unsigned IDX_DR   = 1;
  localparam int unsigned IDX_PC   = 2;
  localparam int unsigned IDX_IR   = 3;
  localparam int unsigned IDX_AC   = 4;
  localparam int unsigned GPR_BASE = 5;

  // Wide enough for the largest legal configuration (27 GPRs -> 34 entries)
  typedef logic [5:0] rf_idx_t;

  function automatic int unsigned sel_w(input int unsigned num_gpr);
    return $clog2(7 + num_gpr);
  endfunction

endpackage

// File: rtl/param_register_file_gpr.sv
// One general-purpose register: clear beats write, write beats increment.
// With RF_INC_SATURATE_EN the increment sticks at all-ones and flags it.
module rf_gpr_cell #(
  parameter int unsigned DATA_W = 16,
  parameter logic        INC_EN = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wen,
  input  logic [DATA_W-1:0] wdata,
  input  logic              inc,
`ifdef RF_INC_SATURATE_EN
  output logic              sat,
`endif
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] q_r;
  logic [DATA_W-1:0] d_s;
  logic              bump_s;

  // Next-state selection in priority order
  always_comb begin
    bump_s = INC_EN && inc && !clr && !wen;
`ifdef RF_INC_SATURATE_EN
    sat = bump_s && (q_r == {DATA_W{1'b1}});
`endif
    if (clr) begin
      d_s = '0;
    end else if (wen) begin
      d_s = wdata;
    end else if (bump_s) begin
`ifdef RF_INC_SATURATE_EN
      d_s = (q_r == {DATA_W{1'b1}}) ? q_r : q_r + DATA_W'(1);
`else
      d_s = q_r + DATA_W'(1);
`endif
    end else begin
      d_s = q_r;
    end
  end

  // Register storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= '0;
    end else begin
      q_r <= d_s;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/param_register_file.sv
// Core datapath register file: AR/DR/PC/IR/AC, NUM_GPR general registers and
// constant IDX/IDY. Optional macro RF_INC_SATURATE_EN adds saturation + INC_SAT.
module param_register_file
  import rf_pkg::*;
#(
  parameter int unsigned          DATA_W   = 16,
  parameter int unsigned          NUM_GPR  = 7,
  parameter logic [DATA_W-1:0]    CORE_X   = '0,
  parameter logic [DATA_W-1:0]    CORE_Y   = '0,
  parameter logic [NUM_GPR-1:0]   INC_MASK = 7'b0000010
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        WEN,
  input  logic [sel_w(NUM_GPR)-1:0]   WSEL,
  input  logic                        REN,
  input  logic [sel_w(NUM_GPR)-1:0]   RSEL,
  input  logic                        MEMREAD,
  input  logic [DATA_W-1:0]           DIN,
  input  logic [DATA_W-1:0]           BIN,
  input  logic [DATA_W-1:0]           INSIN,
  input  logic [NUM_GPR-1:0]          CLR,
  input  logic [NUM_GPR-1:0]          INC,
  input  logic                        PCINC,
  input  logic                        ALU_LD,
  input  logic [sel_w(NUM_GPR)-1:0]   ALU_SEL,
  output logic [DATA_W-1:0]           BOUT,
  output logic [DATA_W-1:0]           ALUOUT,
  output logic [DATA_W-1:0]           DMADDR,
  output logic [DATA_W-1:0]           IMADDR,
  output logic [DATA_W-1:0]           DOUT,
  output logic [DATA_W-1:0]           ACOUT,
  output logic [DATA_W-1:0]           IROUT,
`ifdef RF_INC_SATURATE_EN
  output logic                        INC_SAT,
`endif
  output logic                        RD_ERR
);

  localparam int unsigned        SEL_W   = sel_w(NUM_GPR);
  localparam int unsigned        NUM_REG = 7 + NUM_GPR;
  localparam int unsigned        IDX_X   = GPR_BASE + NUM_GPR;
  localparam int unsigned        IDX_Y   = IDX_X + 1;
  localparam logic [SEL_W-1:0]   MAX_SEL = SEL_W'(IDX_Y);

  logic [DATA_W-1:0]  ar_r, dr_r, pc_r, ir_r, ac_r, alu_r;
  logic               rd_err_r;
  logic [DATA_W-1:0]  wdata_s, regout_s, alu_d_s, pc_nxt_s;
  logic               wr_ok_s, err_s;
  logic               we_ar_s, we_dr_s, we_pc_s, we_ir_s, we_ac_s;
  logic [NUM_GPR-1:0] gpr_we_s;
  logic [DATA_W-1:0]  gpr_q_s [NUM_GPR];
  logic [DATA_W-1:0]  regs_s  [NUM_REG];
`ifdef RF_INC_SATURATE_EN
  logic               inc_sat_r;
  logic               pc_sat_s;
  logic [NUM_GPR-1:0] gpr_sat_s;
`endif

  // Write decode and illegal-index detection; IDX/IDY decode to no target
  always_comb begin
    wdata_s = MEMREAD ? DIN : BIN;
    wr_ok_s = WEN && (WSEL <= MAX_SEL);
    err_s   = (REN && (RSEL > MAX_SEL)) || (WEN && (WSEL > MAX_SEL)) ||
              (ALU_LD && (ALU_SEL > MAX_SEL));
    we_ar_s = wr_ok_s && (WSEL == SEL_W'(IDX_AR));
    we_dr_s = wr_ok_s && (WSEL == SEL_W'(IDX_DR));
    we_pc_s = wr_ok_s && (WSEL == SEL_W'(IDX_PC));
    we_ir_s = wr_ok_s && (WSEL == SEL_W'(IDX_IR));
    we_ac_s = wr_ok_s && (WSEL == SEL_W'(IDX_AC));
    for (int g = 0; g < NUM_GPR; g++) begin
      gpr_we_s[g] = wr_ok_s && (WSEL == SEL_W'(GPR_BASE + g));
    end
  end

  // PC next value: a bus write overrides the increment
  always_comb begin
    pc_nxt_s = pc_r;
`ifdef RF_INC_SATURATE_EN
    pc_sat_s = 1'b0;
`endif
    if (we_pc_s) begin
      pc_nxt_s = wdata_s;
    end else if (PCINC) begin
`ifdef RF_INC_SATURATE_EN
      pc_sat_s = (pc_r == {DATA_W{1'b1}});
      pc_nxt_s = pc_sat_s ? pc_r : pc_r + DATA_W'(1);
`else
      pc_nxt_s = pc_r + DATA_W'(1);
`endif
    end else begin
      pc_nxt_s = pc_r;
    end
  end

  for (genvar g = 0; g < NUM_GPR; g++) begin : g_gpr
    rf_gpr_cell #(
      .DATA_W (DATA_W),
      .INC_EN (INC_MASK[g])
    ) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (CLR[g]),
      .wen   (gpr_we_s[g]),
      .wdata (wdata_s),
      .inc   (INC[g]),
`ifdef RF_INC_SATURATE_EN
      .sat   (gpr_sat_s[g]),
`endif
      .q     (gpr_q_s[g])
    );
  end

  // Flatten the index map and select the read and ALU operands
  always_comb begin
    regs_s[IDX_AR] = ar_r;
    regs_s[IDX_DR] = dr_r;
    regs_s[IDX_PC] = pc_r;
    regs_s[IDX_IR] = ir_r;
    regs_s[IDX_AC] = ac_r;
    for (int g = 0; g < NUM_GPR; g++) begin
      regs_s[GPR_BASE + g] = gpr_q_s[g];
    end
    regs_s[IDX_X] = CORE_X;
    regs_s[IDX_Y] = CORE_Y;
    regout_s = '0;
    alu_d_s  = '0;
    for (int i = 0; i < NUM_REG; i++) begin
      regout_s = (REN && (RSEL == SEL_W'(i))) ? regs_s[i] : regout_s;
      alu_d_s  = (ALU_SEL == SEL_W'(i)) ? regs_s[i] : alu_d_s;
    end
  end

  // Special-purpose registers, ALU operand latch and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_r     <= '0;
      dr_r     <= '0;
      pc_r     <= '0;
      ir_r     <= '0;
      ac_r     <= '0;
      alu_r    <= '0;
      rd_err_r <= 1'b0;
`ifdef RF_INC_SATURATE_EN
      inc_sat_r <= 1'b0;
`endif
    end else begin
      if (we_ar_s) ar_r <= wdata_s;
      if (we_dr_s) dr_r <= wdata_s;
      if (we_ir_s) ir_r <= INSIN;
      if (we_ac_s) ac_r <= wdata_s;
      pc_r <= pc_nxt_s;
      if (ALU_LD) alu_r <= alu_d_s;
      rd_err_r <= rd_err_r | err_s;
`ifdef RF_INC_SATURATE_EN
      inc_sat_r <= inc_sat_r | pc_sat_s | (|gpr_sat_s);
`endif
    end
  end

  assign BOUT   = MEMREAD ? DIN : regout_s;
  assign ALUOUT = alu_r;
  assign DMADDR = ar_r;
  assign IMADDR = pc_r;
  assign DOUT   = dr_r;
  assign ACOUT  = ac_r;
  assign IROUT  = ir_r;
  assign RD_ERR = rd_err_r;
`ifdef RF_INC_SATURATE_EN
  assign INC_SAT = inc_sat_r;
`endif

endmodule

// File: tb/tb_param_register_file.sv
// Self-checking bench: directed pins from the test plan, then random traffic
// compared every cycle against an array-based reference model.
module tb_param_register_file;

  localparam int          NR   = 14;
  localparam logic [15:0] CX   = 16'h0003;
  localparam logic [15:0] CY   = 16'h0005;
  localparam logic [6:0]  MASK = 7'b0000010;
`ifdef RF_INC_SATURATE_EN
  localparam logic [15:0] WRAP_VAL = 16'hFFFF;
`else
  localparam logic [15:0] WRAP_VAL = 16'h0000;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        WEN, REN, MEMREAD, PCINC, ALU_LD;
  logic [3:0]  WSEL, RSEL, ALU_SEL;
  logic [15:0] DIN, BIN, INSIN;
  logic [6:0]  CLR, INC;
  logic [15:0] BOUT, ALUOUT, DMADDR, IMADDR, DOUT, ACOUT, IROUT;
  logic        RD_ERR;
`ifdef RF_INC_SATURATE_EN
  logic        INC_SAT;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  param_register_file #(
    .DATA_W (16), .NUM_GPR (7), .CORE_X (CX), .CORE_Y (CY), .INC_MASK (MASK)
  ) dut (
    .clk (clk), .rst_n (rst_n), .WEN (WEN), .WSEL (WSEL), .REN (REN), .RSEL (RSEL),
    .MEMREAD (MEMREAD), .DIN (DIN), .BIN (BIN), .INSIN (INSIN), .CLR (CLR), .INC (INC),
    .PCINC (PCINC), .ALU_LD (ALU_LD), .ALU_SEL (ALU_SEL), .BOUT (BOUT), .ALUOUT (ALUOUT),
    .DMADDR (DMADDR), .IMADDR (IMADDR), .DOUT (DOUT), .ACOUT (ACOUT), .IROUT (IROUT),
`ifdef RF_INC_SATURATE_EN
    .INC_SAT (INC_SAT),
`endif
    .RD_ERR (RD_ERR)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_reg [NR];
  logic [15:0] n_reg [NR];
  logic [15:0] m_alu, n_alu;
  logic        m_err, n_err;
  logic        m_sat, n_sat;

  function automatic logic [15:0] bump(input logic [15:0] v);
`ifdef RF_INC_SATURATE_EN
    return (v == 16'hFFFF) ? v : v + 16'd1;
`else
    return v + 16'd1;
`endif
  endfunction

  // Later assignments override earlier ones: increment < write < clear
  always_comb begin
    for (int i = 0; i < NR; i++) n_reg[i] = m_reg[i];
    n_sat = m_sat;
    if (PCINC) begin
      n_reg[2] = bump(m_reg[2]);
      if (m_reg[2] == 16'hFFFF && !(WEN && WSEL == 4'd2)) n_sat = 1'b1;
    end
    for (int g = 0; g < 7; g++) begin
      if (INC[g] && MASK[g]) begin
        n_reg[5+g] = bump(m_reg[5+g]);
        if (m_reg[5+g] == 16'hFFFF && !CLR[g] && !(WEN && int'(WSEL) == 5 + g)) n_sat = 1'b1;
      end
    end
    if (WEN && WSEL < 4'd12) n_reg[WSEL] = (WSEL == 4'd3) ? INSIN : (MEMREAD ? DIN : BIN);
    for (int g = 0; g < 7; g++) begin
      if (CLR[g]) n_reg[5+g] = 16'h0000;
    end
    n_alu = ALU_LD ? ((ALU_SEL < 4'd14) ? m_reg[ALU_SEL] : 16'h0000) : m_alu;
    n_err = m_err | (REN && RSEL > 4'd13) | (WEN && WSEL > 4'd13) | (ALU_LD && ALU_SEL > 4'd13);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) m_reg[i] <= (i == 12) ? CX : ((i == 13) ? CY : 16'h0000);
      m_alu <= 16'h0000;
      m_err <= 1'b0;
      m_sat <= 1'b0;
    end else begin
      m_reg <= n_reg;
      m_alu <= n_alu;
      m_err <= n_err;
      m_sat <= n_sat;
    end
  end

  function automatic logic [15:0] exp_bout();
    if (MEMREAD) return DIN;
    if (REN && RSEL < 4'd14) return m_reg[RSEL];
    return 16'h0000;
  endfunction

  // Compare process: every falling edge, away from the active edge
  always @(negedge clk) begin
    chk("dmaddr", DMADDR, m_reg[0]);
    chk("dout",   DOUT,   m_reg[1]);
    chk("imaddr", IMADDR, m_reg[2]);
    chk("irout",  IROUT,  m_reg[3]);
    chk("acout",  ACOUT,  m_reg[4]);
    chk("aluout", ALUOUT, m_alu);
    chk("rd_err", {15'd0, RD_ERR}, {15'd0, m_err});
    chk("bout",   BOUT,   exp_bout());
`ifdef RF_INC_SATURATE_EN
    chk("inc_sat", {15'd0, INC_SAT}, {15'd0, m_sat});
`endif
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    WEN = 1'b0; REN = 1'b0; MEMREAD = 1'b0; PCINC = 1'b0; ALU_LD = 1'b0;
    WSEL = 4'd0; RSEL = 4'd0; ALU_SEL = 4'd0;
    DIN = 16'h0000; BIN = 16'h0000; INSIN = 16'h0000; CLR = 7'd0; INC = 7'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  function automatic logic [3:0] rnd_sel();
    if ($urandom_range(0, 19) == 0) return 4'($urandom_range(14, 15));
    return 4'($urandom_range(0, 13));
  endfunction

  initial begin
    idle();
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_dmaddr", DMADDR, 16'h0000);
    chk("rst_imaddr", IMADDR, 16'h0000);
    chk("rst_dout",   DOUT,   16'h0000);
    chk("rst_acout",  ACOUT,  16'h0000);
    chk("rst_irout",  IROUT,  16'h0000);
    chk("rst_aluout", ALUOUT, 16'h0000);
    chk("rst_rd_err", {15'd0, RD_ERR}, 16'h0000);
    chk("rst_bout",   BOUT,   16'h0000);
    rst_n = 1'b1;
    REN = 1'b1; RSEL = 4'd12; #1 chk("idx_read", BOUT, 16'h0003);
    RSEL = 4'd13;             #1 chk("idy_read", BOUT, 16'h0005);

    tick(); WEN = 1'b1; WSEL = 4'd5; BIN = 16'hA5A5; REN = 1'b1; RSEL = 4'd5;
    #1 chk("same_cycle_read", BOUT, 16'h0000);
    tick(); REN = 1'b1; RSEL = 4'd5; #1 chk("r1_read", BOUT, 16'hA5A5);

    tick(); MEMREAD = 1'b1; DIN = 16'h1234; WEN = 1'b1; WSEL = 4'd1;
    #1 chk("memread_bout", BOUT, 16'h1234);
    tick(); chk("dout_mem", DOUT, 16'h1234);

    WEN = 1'b1; WSEL = 4'd6; BIN = 16'hFFFF;
    tick(); INC = 7'b0000010;
    tick(); REN = 1'b1; RSEL = 4'd6; #1 chk("r2_wrap", BOUT, WRAP_VAL);
    tick(); CLR = 7'b0000010; WEN = 1'b1; WSEL = 4'd6; BIN = 16'h0055; INC = 7'b0000010;
    tick(); REN = 1'b1; RSEL = 4'd6; #1 chk("clr_priority", BOUT, 16'h0000);
    tick(); WEN = 1'b1; WSEL = 4'd6; BIN = 16'h0007; INC = 7'b0000010;
    tick(); REN = 1'b1; RSEL = 4'd6; #1 chk("wen_over_inc", BOUT, 16'h0007);
    tick(); INC = 7'b0000001;
    tick(); REN = 1'b1; RSEL = 4'd5; #1 chk("r1_inc_masked", BOUT, 16'hA5A5);

    tick(); WEN = 1'b1; WSEL = 4'd2; BIN = 16'hFFFE;
    tick(); PCINC = 1'b1;
    tick(); chk("pc_ffff", IMADDR, 16'hFFFF); PCINC = 1'b1;
    tick(); chk("pc_wrap", IMADDR, WRAP_VAL);
    ALU_LD = 1'b1; ALU_SEL = 4'd12;
    tick(); chk("alu_idx", ALUOUT, 16'h0003);

    chk("err_clear", {15'd0, RD_ERR}, 16'h0000);
    WEN = 1'b1; WSEL = 4'd15; BIN = 16'hDEAD;  // 31 truncates to 15: still illegal
    tick(); chk("err_set", {15'd0, RD_ERR}, 16'h0001);
    REN = 1'b1; RSEL = 4'd5; #1 chk("r1_after_illegal", BOUT, 16'hA5A5);
    repeat (3) tick();
    chk("err_sticky", {15'd0, RD_ERR}, 16'h0001);
    rst_n = 1'b0;
    #1 chk("err_reset", {15'd0, RD_ERR}, 16'h0000);
    rst_n = 1'b1;

    for (int k = 0; k < 3000; k++) begin
      WEN     = ($urandom_range(0, 2) == 0);
      WSEL    = rnd_sel();
      REN     = ($urandom_range(0, 1) == 1);
      RSEL    = rnd_sel();
      MEMREAD = ($urandom_range(0, 3) == 0);
      DIN     = 16'($urandom);
      BIN     = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      INSIN   = 16'($urandom);
      CLR     = 7'($urandom & $urandom & $urandom);
      INC     = 7'($urandom);
      PCINC   = ($urandom_range(0, 1) == 1);
      ALU_LD  = ($urandom_range(0, 1) == 1);
      ALU_SEL = rnd_sel();
      if ($urandom_range(0, 149) == 0) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      tick();
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
